// File: rtl/m_ifetch.sv
// Instruction fetch: PC generation, sync-memory tracking, 2-entry fetch buffer.
// Redirect has the highest priority; outputs come from registers only.
module m_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc,
    output logic [31:0] w_imem_addr,
    input  logic [31:0] w_imem_data,
    output logic        w_out_valid,
    input  logic        w_out_ready,
    output logic [31:0] w_out_pc,
    output logic [31:0] w_out_inst
);

    logic [31:0] r_pc;
    logic        r_infl_v;
    logic [31:0] r_infl_pc;
    logic [31:0] r_q_pc   [2];
    logic [31:0] r_q_inst [2];
    logic [1:0]  r_count;

    logic        fire;
    logic        issue;
    logic        push;
    logic [2:0]  occ;
    logic [1:0]  lvl;
    logic        wr_idx;
    logic        unused_bits;

    assign unused_bits = ^w_redirect_pc[1:0];

    always_comb begin
        fire   = (r_count != 2'd0) & w_out_ready;
        occ    = {1'b0, r_count} - {2'b00, fire} + {2'b00, r_infl_v};
        issue  = !w_redirect & (occ < 3'd2);
        push   = r_infl_v & !w_redirect;
        lvl    = r_count - {1'b0, fire};
        wr_idx = lvl[0];
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pc        <= RESET_PC;
            r_infl_v    <= 1'b0;
            r_infl_pc   <= 32'h0;
            r_q_pc[0]   <= 32'h0;
            r_q_pc[1]   <= 32'h0;
            r_q_inst[0] <= 32'h0;
            r_q_inst[1] <= 32'h0;
            r_count     <= 2'd0;
        end else if (w_redirect) begin
            r_pc     <= {w_redirect_pc[31:2], 2'b00};
            r_infl_v <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (issue) begin
                r_infl_v  <= 1'b1;
                r_infl_pc <= r_pc;
                r_pc      <= r_pc + 32'(PC_STEP);
            end else begin
                r_infl_v  <= 1'b0;
            end
            if (fire) begin
                r_q_pc[0]   <= r_q_pc[1];
                r_q_inst[0] <= r_q_inst[1];
            end
            // push after shift so a same-cycle write to slot 0 wins
            if (push) begin
                r_q_pc[wr_idx]   <= r_infl_pc;
                r_q_inst[wr_idx] <= w_imem_data;
            end
            r_count <= r_count - {1'b0, fire} + {1'b0, push};
        end
    end

    assign w_imem_addr = r_pc;
    assign w_out_valid = (r_count != 2'd0);
    assign w_out_pc    = r_q_pc[0];
    assign w_out_inst  = r_q_inst[0];

endmodule
